// File: rtl/prio_enc_drain.sv
// Sequential priority encoder: accepts an N-bit request vector and emits each set index, highest first.
// Optional PENC_EMPTY_BEAT_EN: an accepted all-zero vector produces a single out_empty beat.
module prio_enc_drain #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in_vec,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_idx,
   output logic         out_valid,
   input  logic         out_ready,
`ifdef PENC_EMPTY_BEAT_EN
   output logic         out_empty,
`endif
   output logic         out_last
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [N-1:0] r_pend;
   logic [N-1:0] w_pend_nxt;
   logic [N-1:0] w_pend_clr;
   logic [W-1:0] r_out_idx;
   logic [W-1:0] w_idx_nxt;
   logic         r_out_valid;
   logic         w_valid_nxt;
   logic         r_out_last;
   logic         w_last_nxt;
`ifdef PENC_EMPTY_BEAT_EN
   logic         r_out_empty;
   logic         w_empty_nxt;
`endif

   // Full-width search; the last set bit seen in ascending order wins.
   function automatic logic [W-1:0] f_hi_idx(input logic [N-1:0] v);
      logic [W-1:0] idx;
      idx = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (v[i]) idx = W'(i);
      end
      return idx;
   endfunction

   function automatic logic f_one_hot(input logic [N-1:0] v);
      return (v != '0) && ((v & (v - N'(1))) == '0);
   endfunction

   assign w_pend_clr = r_pend & ~(N'(1) << r_out_idx);
   assign in_ready   = (r_state == S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pend      <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
`ifdef PENC_EMPTY_BEAT_EN
         r_out_empty <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_pend      <= w_pend_nxt;
         r_out_idx   <= w_idx_nxt;
         r_out_valid <= w_valid_nxt;
         r_out_last  <= w_last_nxt;
`ifdef PENC_EMPTY_BEAT_EN
         r_out_empty <= w_empty_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend;
      w_idx_nxt   = r_out_idx;
      w_valid_nxt = r_out_valid;
      w_last_nxt  = r_out_last;
`ifdef PENC_EMPTY_BEAT_EN
      w_empty_nxt = r_out_empty;
`endif
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               if (in_vec != '0) begin
                  w_state_nxt = S_DRAIN;
                  w_pend_nxt  = in_vec;
                  w_idx_nxt   = f_hi_idx(in_vec);
                  w_valid_nxt = 1'b1;
                  w_last_nxt  = f_one_hot(in_vec);
               end
`ifdef PENC_EMPTY_BEAT_EN
               else begin
                  w_state_nxt = S_DRAIN;
                  w_pend_nxt  = '0;
                  w_idx_nxt   = '0;
                  w_valid_nxt = 1'b1;
                  w_last_nxt  = 1'b1;
                  w_empty_nxt = 1'b1;
               end
`endif
            end
         end
         S_DRAIN: begin
            // Stalled beats leave every register untouched.
            if (r_out_valid && out_ready) begin
               w_pend_nxt = w_pend_clr;
               if (r_out_last) begin
                  w_state_nxt = S_IDLE;
                  w_valid_nxt = 1'b0;
                  w_last_nxt  = 1'b0;
`ifdef PENC_EMPTY_BEAT_EN
                  w_empty_nxt = 1'b0;
`endif
               end else begin
                  w_idx_nxt  = f_hi_idx(w_pend_clr);
                  w_last_nxt = f_one_hot(w_pend_clr);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign out_idx   = r_out_idx;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
`ifdef PENC_EMPTY_BEAT_EN
   assign out_empty = r_out_empty;
`endif

endmodule
